// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache fill controller.
package cache_fill_pkg;

  // Controller states.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Mask covering the byte offset within one cache block.
  function automatic logic [63:0] blk_off_mask(input int unsigned words,
                                               input int unsigned word_bytes);
    return (64'd1 << clog2(words * word_bytes)) - 64'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping.
module rr_arbiter
  import cache_fill_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned GID_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [GID_W-1:0] i_rr_ptr,
  output logic [GID_W-1:0] o_gnt_id,
  output logic             o_any
);

  // Scan requesters in circular order starting at the pointer.
  always_comb begin
    logic found;
    found    = 1'b0;
    o_gnt_id = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if (!found && i_req[j] && (j == ((int'(i_rr_ptr) + k) % int'(NREQ)))) begin
          found    = 1'b1;
          o_gnt_id = GID_W'(j);
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Multi-requester cache miss handler: arbitrates misses, issues block reads,
// steers returning words into the granted cache and writes its tag last.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WORDS      = 8,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned NREQ       = 2,
  localparam int unsigned WN_W      = clog2(WORDS),
  localparam int unsigned GID_W     = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        miss_detected,
  input  logic [NREQ*ADDR_W-1:0] miss_address,
  input  logic                   memory_data_valid,
  output logic [NREQ-1:0]        fsm_busy,
  output logic                   mem_read,
  output logic [ADDR_W-1:0]      memory_address,
  output logic [NREQ-1:0]        write_data_array,
  output logic [NREQ-1:0]        write_tag_array,
  output logic [WN_W-1:0]        word_num,
  output logic [GID_W-1:0]       grant_id
);

  localparam int unsigned CNT_W = WN_W + 1;
  localparam logic [CNT_W-1:0]  NumWords = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LastWord = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(blk_off_mask(WORDS, WORD_BYTES));

  fill_state_e       r_state, w_state_d;
  logic [GID_W-1:0]  r_grant, w_grant_d;
  logic [ADDR_W-1:0] r_base, w_base_d;
  logic [CNT_W-1:0]  r_issue_cnt, w_issue_d;
  logic [CNT_W-1:0]  r_recv_cnt, w_recv_d;
  logic [GID_W-1:0]  r_rr_ptr, w_rr_ptr_d;

  logic [GID_W-1:0]  w_gnt_id;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [ADDR_W-1:0] w_base_new;
  logic [ADDR_W-1:0] w_offset;
  logic [NREQ-1:0]   w_gnt_dec;
  logic              w_wr_data;
  logic              w_wr_tag;

  rr_arbiter #(
    .NREQ  (NREQ),
    .GID_W (GID_W)
  ) u_rr_arbiter (
    .i_req    (miss_detected),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  // Select the winning miss address and decode the latched grant.
  always_comb begin
    w_sel_addr = '0;
    w_gnt_dec  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_gnt_id == GID_W'(i)) w_sel_addr = miss_address[i*ADDR_W +: ADDR_W];
      if (r_grant == GID_W'(i)) w_gnt_dec[i] = 1'b1;
    end
  end

  assign w_base_new = w_sel_addr & ~OffMask;
  // Base is block aligned, so this offset never carries out of the block.
  assign w_offset   = ADDR_W'(r_issue_cnt) * ADDR_W'(WORD_BYTES);

  // Next-state and combinational outputs.
  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_base_d       = r_base;
    w_issue_d      = r_issue_cnt;
    w_recv_d       = r_recv_cnt;
    w_rr_ptr_d     = r_rr_ptr;
    mem_read       = 1'b0;
    memory_address = '0;
    w_wr_data      = 1'b0;
    w_wr_tag       = 1'b0;
    word_num       = '0;
    grant_id       = '0;
    unique case (r_state)
      IDLE: begin
        // First read issues in the same cycle the miss is seen.
        if (w_any) begin
          grant_id       = w_gnt_id;
          mem_read       = 1'b1;
          memory_address = w_base_new;
          w_grant_d      = w_gnt_id;
          w_base_d       = w_base_new;
          w_issue_d      = CNT_W'(1);
          w_recv_d       = '0;
          w_state_d      = FILL;
        end
      end
      FILL: begin
        grant_id = r_grant;
        if (r_issue_cnt < NumWords) begin
          mem_read       = 1'b1;
          memory_address = r_base + w_offset;
          w_issue_d      = r_issue_cnt + CNT_W'(1);
        end
        // Words beyond what has been requested are stale; drop them.
        if (memory_data_valid && (r_recv_cnt < r_issue_cnt)) begin
          w_wr_data = 1'b1;
          word_num  = r_recv_cnt[WN_W-1:0];
          w_recv_d  = r_recv_cnt + CNT_W'(1);
          if (r_recv_cnt == LastWord) begin
            w_wr_tag   = 1'b1;
            w_state_d  = IDLE;
            w_rr_ptr_d = (r_grant == GID_W'(NREQ - 1)) ? '0 : r_grant + GID_W'(1);
          end
        end
      end
    endcase
  end

  assign write_data_array = w_wr_data ? w_gnt_dec : '0;
  assign write_tag_array  = w_wr_tag ? w_gnt_dec : '0;
  assign fsm_busy         = miss_detected | ((r_state == FILL) ? w_gnt_dec : '0);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_grant     <= w_grant_d;
      r_base      <= w_base_d;
      r_issue_cnt <= w_issue_d;
      r_recv_cnt  <= w_recv_d;
      r_rr_ptr    <= w_rr_ptr_d;
    end
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised, multi-requester cache miss handler. It sits between up to NREQ cache tag-match stages (instruction and data cache in Stage 3) and the shared pipelined main memory. It arbitrates misses round-robin and aligns the miss address to its block base. It then issues one memory read per cycle and steers returning words into the winning cache's data array, writing the tag on the last word. Block size, word size, address width and requester count are all parameters.

## Interface
- ADDR_W, 16, address width in bits
- WORDS, 8, words per cache block; power of 2, ≥2
- WORD_BYTES, 2, bytes per word; power of 2
- NREQ, 2, number of requesting caches, 1..4; index 0 = D-cache, 1 = I-cache
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- miss_detected  in  NREQ  per-requester miss; held high until that requester's fill completes
- miss_address  in  NREQ*ADDR_W  per-requester miss address; slice i = [i*ADDR_W +: ADDR_W]
- memory_data_valid  in  1  returning memory word valid, in issue order
- fsm_busy  out  NREQ  per-requester stall
- mem_read  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  read address; 0 when mem_read low
- write_data_array  out  NREQ  data-array write enable for the granted cache
- write_tag_array  out  NREQ  tag/valid write enable, last word only
- word_num  out  clog2(WORDS)  word index for write_data_array
- grant_id  out  clog2(NREQ) (min 1)  requester currently being served

## Operation
- States: IDLE, FILL. Registers: state, grant, base (ADDR_W), issue_cnt and recv_cnt (each clog2(WORDS)+1 bits), rr_ptr.
- IDLE:
  - If any miss_detected is set, the arbiter picks the first set requester at or after rr_ptr (circular).
  - That same cycle: latch grant, latch base = miss_address[g] with the low clog2(WORDS*WORD_BYTES) bits cleared, mem_read=1, memory_address=base, issue_cnt←1, recv_cnt←0, next state FILL.
  - If no miss: all outputs 0, state holds.
- FILL:
  - mem_read=1 while issue_cnt<WORDS; memory_address = base + issue_cnt*WORD_BYTES; issue_cnt increments each issuing cycle.
  - On memory_data_valid: write_data_array[grant]=1, word_num=recv_cnt[clog2(WORDS)-1:0], recv_cnt increments.
  - On memory_data_valid with recv_cnt==WORDS-1: write_tag_array[grant]=1 as well; next state IDLE; rr_ptr←(grant+1) mod NREQ.
- fsm_busy[i] = miss_detected[i] | (state==FILL & grant==i).
- Non-granted requesters stay stalled and are considered in the next IDLE cycle.
- memory_data_valid in IDLE is ignored. In FILL it is honoured only while recv_cnt<issue_cnt; a valid with recv_cnt≥issue_cnt is ignored.
- Arithmetic: the base is block aligned, so base + offset never crosses a block or wraps ADDR_W.
- Reset:
  - All registers clear: state IDLE, counters 0, rr_ptr 0, grant 0.
  - All outputs read 0 in the first cycle after reset unless a miss is already present.
  - A reset mid-fill abandons the fill without a tag write. Memory words still in flight arrive in IDLE and are ignored.

## Timing
- Zero-cycle start: the first read issues in the same cycle miss_detected is seen in IDLE.
- Reads issue on WORDS consecutive cycles. The controller tolerates any memory latency L≥1 and bubbles in memory_data_valid.
- With no bubbles, tag write occurs L+WORDS-1 cycles after the start cycle; for L=4, WORDS=8 that is cycle 11.
- The served requester's fsm_busy covers cycles 0..11.
- After the tag-write cycle, one IDLE cycle passes before the next grant. The served cache re-looks-up and hits in that cycle.
- All outputs except the registered state are combinational from state, counters and inputs. There is no output register stage.

## Structure
- Package cache_fill_pkg holds:
  - state encoding localparams (IDLE, FILL)
  - the block-offset mask function
  - a clog2 helper for the counter and word_num widths
- Sub-module rr_arbiter:
  - ports: NREQ request vector, rr_ptr in, one-hot/binary grant out, any-request flag
  - purely combinational
  - rr_ptr stays in cache_fill_ctrl

## Test plan
- NREQ=2, WORDS=8, WORD_BYTES=2, L=4; req1 miss 0x1236 -> memory_address 0x1230,0x1232…0x123E on cycles 0–7; write_data_array[1] with word_num 0–7 on cycles 4–11; write_tag_array[1] on cycle 11 only; fsm_busy[1] high cycles 0–11.
- Reset, then req0 and req1 miss simultaneously -> req0 served first (grant_id 0) while fsm_busy[1] stays high; req1 served next. A third simultaneous pair is served req0 first again, since rr_ptr returned to 0.
- memory_data_valid with bubbles (valid, 0, 0, valid, …) -> word_num advances only on valid; mem_read drops after exactly 8 issues; tag written on the 8th valid.
- Reset asserted in the cycle of the word-3 return -> next cycle all outputs 0, no tag write, later valids ignored. A new miss 0x0040 then fills words 0–7 from 0x0040.
- Miss 0xFFFF -> base 0xFFF0, last address 0xFFFE, no wrap past 0xFFFF.
- Parameter variant WORDS=4, WORD_BYTES=4, NREQ=1; miss 0x0107 -> addresses 0x0100, 0x0104, 0x0108, 0x010C; word_num 0–3; grant_id constant 0.
